// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: single outstanding word request, fixed LATENCY, one-cycle response pulse.
// Optional address checking is enabled with `define DMEM_ERR_EN (misaligned / out-of-range -> err).
module dmem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam bit LAT1 = (LATENCY == 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic          r_req_err;
  logic          r_resp_valid;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_req_err;
  logic [AW-1:0] w_req_idx;
  logic          w_wait_done;
  logic          w_enter_resp;
  logic          w_op_we;
  logic [AW-1:0] w_op_idx;
  logic [31:0]   w_op_wdata;
  logic          w_op_err;

  assign w_req_idx = req_addr[AW+1:2];

`ifdef DMEM_ERR_EN
  assign w_req_err = (req_addr[1:0] != 2'b00) || (|req_addr[31:AW+2]);
`else
  logic w_unused_addr;
  assign w_unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign w_req_err     = 1'b0;
`endif

  assign req_ready = (r_state != S_WAIT);
  assign w_accept  = req_valid & req_ready;
  // Combinational so the pipeline stalls already in the accept cycle.
  assign busy      = (r_state == S_WAIT) | (w_accept & !LAT1);

  // With LATENCY = 1 the operation executes straight from the request inputs.
  assign w_wait_done  = (r_state == S_WAIT) && (r_cnt == CW'(1));
  assign w_enter_resp = w_wait_done | (LAT1 & w_accept);
  assign w_op_we      = w_wait_done ? r_we      : req_we;
  assign w_op_idx     = w_wait_done ? r_idx     : w_req_idx;
  assign w_op_wdata   = w_wait_done ? r_wdata   : req_wdata;
  assign w_op_err     = w_wait_done ? r_req_err : w_req_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_req_err    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_resp_valid <= w_enter_resp;
      r_err        <= w_enter_resp & w_op_err;
      if (w_enter_resp) begin
        r_rdata <= (w_op_we || w_op_err) ? 32'h0 : r_mem[w_op_idx];
      end
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_accept) begin
            r_we      <= req_we;
            r_idx     <= w_req_idx;
            r_wdata   <= req_wdata;
            r_req_err <= w_req_err;
            r_cnt     <= CNT_LOAD;
            r_state   <= LAT1 ? S_RESP : S_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_RESP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stores commit on the response edge only; a reset on that edge drops them.
  always_ff @(posedge clk) begin
    if (reset && w_enter_resp && w_op_we && !w_op_err) begin
      r_mem[w_op_idx] <= w_op_wdata;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign err        = r_err;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined MIPS core: the far end of the M-stage load/store interface. It accepts one word request at a time from the memory stage, serves it from an internal word-addressed RAM after a fixed programmable latency, and returns read data with a one-cycle response pulse. It also drives a busy flag, which the hazard unit uses to stall F/D/E/M while a request is outstanding.

## Interface
- DEPTH, 64, RAM size in 32-bit words; power of two, ≥ 4.
- LATENCY, 2, cycles from request accept to response; ≥ 1.
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset; active when 0, sampled on the clk rising edge.
- req_valid  input  1  request present.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address (ALUOutM).
- req_wdata  input  32  store data (WriteDataM).
- req_ready  output  1  responder can accept a request this cycle.
- resp_valid  output  1  single-cycle response pulse.
- resp_rdata  output  32  load data; valid only while resp_valid = 1.
- busy  output  1  request accepted and not yet responded.
- err  output  1  error flag, qualified by resp_valid (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESP.
- Accept = req_valid & req_ready. req_ready = 1 in IDLE and RESP, 0 in WAIT.
- On accept, latch we, addr and wdata. Load the counter with LATENCY-1. Next state is RESP if LATENCY = 1, else WAIT.
- WAIT: decrement the counter each cycle. When the counter is 1, next state is RESP.
- Entering RESP (on that clock edge):
  - a store writes wdata to RAM[addr word index];
  - a load registers RAM[index] into resp_rdata;
  - resp_valid is 1 for the whole RESP cycle.
- RESP with a new accept: follow the accept rules above (back-to-back requests). RESP without an accept: go to IDLE.
- Word index = addr[log2(DEPTH)+1:2].
- Stores: resp_valid still pulses. resp_rdata is 0 on store responses.
- There is no response backpressure. The requester must consume the response in the RESP cycle.
- busy = (state == WAIT), or (state == IDLE/RESP with accept and LATENCY > 1). This is a combinational term so the stage stalls in the accept cycle.
- RAM contents are not cleared by reset. Simulation initialises them to 0.

## Timing
- Reset values: state IDLE, counter 0, resp_valid 0, resp_rdata 0, err 0. This gives req_ready 1 and busy 0 on the first cycle after reset.
- Latency: an accept on edge-cycle N gives resp_valid high in cycle N+LATENCY.
- Throughput: one request per LATENCY cycles (back-to-back through RESP).
- RAM writes commit at the response edge, never at accept.
- Reset mid-operation (WAIT or RESP pending): the request is discarded, the store is not committed, and no response is issued.
- Load following a store to the same address: returns the stored value, since the store committed before the load was accepted.
- req_valid while req_ready = 0: ignored. The requester holds the request until accepted.

## Configuration
- DMEM_ERR_EN defined:
  - a request with addr[1:0] ≠ 0 or addr ≥ 4·DEPTH is an error;
  - on an error the store is suppressed, resp_rdata = 0 and err = 1 with resp_valid;
  - latency is unchanged.
- DMEM_ERR_EN undefined:
  - err is tied to 0;
  - addr[1:0] and addresses above the RAM are ignored, and accesses alias modulo DEPTH words.

## Test plan
- Reset release, LATENCY = 2: req_ready = 1, busy = 0, resp_valid = 0, resp_rdata = 0.
- Store 0xDEADBEEF to 0x10 accepted at cycle 0, then load 0x10 accepted at cycle 2 (RESP): resp_valid pulses at cycles 2 and 4, and resp_rdata = 0xDEADBEEF at cycle 4. busy = 1 in cycles 0, 1, 2, 3.
- Load during WAIT: req_valid held, req_ready = 0. The request is accepted only in the RESP cycle, and no request is lost or duplicated.
- reset = 0 during WAIT of a store of 0x12345678 to 0x20: no resp_valid. A later load of 0x20 returns the prior contents (0).
- LATENCY = 1: three back-to-back loads of 0x0, 0x4, 0x8 give resp_valid high for 3 consecutive cycles with the matching data.
- With DMEM_ERR_EN:
  - store to 0x102 (misaligned) gives err = 1 and memory unchanged;
  - load from 0x100 with DEPTH = 64 (out of range) gives err = 1 and resp_rdata = 0.
- Without DMEM_ERR_EN: load from 0x100 returns RAM[0].
